// File: rtl/multiphase_pwm_ctrl.sv
// multiphase_pwm_ctrl: N-phase interleaved PWM with shadowed period/duty/dead-time and per-phase dead-time FSMs
// Ports: clk, rst_n (async active-low); enable, fault; period/duty/deadtime + load strobe into shadow regs;
//        load_ack (shadow became active), cycle_start (master counter wrapped), hs_out/ls_out gate pairs, tripped.
module multiphase_pwm_ctrl #(
  parameter int CNT_W  = 16,
  parameter int NPHASE = 2,
  parameter int DT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              fault,
  input  logic [CNT_W-1:0]  period,
  input  logic [CNT_W-1:0]  duty,
  input  logic [DT_W-1:0]   deadtime,
  input  logic              load,
  output logic              load_ack,
  output logic              cycle_start,
  output logic [NPHASE-1:0] hs_out,
  output logic [NPHASE-1:0] ls_out,
  output logic              tripped
);
  localparam int LG = $clog2(NPHASE);
  typedef enum logic [2:0] {OFF, HS, DT_TO_HS, DT_TO_LS, LS} state_t;
  logic [CNT_W-1:0] cnt, sp, sd, pa, da, pn, dn;
  logic [DT_W-1:0] sdt, ta;
  logic pend, wrap, xfer, halt;
  logic [NPHASE-1:0] r, hs_n, ls_n;
  state_t ps [NPHASE];
  state_t ns [NPHASE];
  logic [DT_W-1:0] dc [NPHASE];
  logic [DT_W-1:0] ndc [NPHASE];
  // clamps applied to the shadow values as they are promoted to active
  assign pn = (sp < CNT_W'(2)) ? CNT_W'(2) : sp;
  assign dn = (sd > pn) ? pn : sd;
  assign wrap = cnt >= pa - CNT_W'(1);
  // while disabled there is no wrap to wait for, so a pending load applies at once
  assign xfer = pend && (!enable || wrap);
  assign halt = !enable || fault || tripped;
  for (genvar i = 0; i < NPHASE; i++) begin : g_ph
    logic [CNT_W+2:0] prod;
    logic [CNT_W:0] sum;
    logic [CNT_W-1:0] off, pc;
    assign prod = {3'b0, pn} * (CNT_W+3)'(i);
    assign sum = {1'b0, cnt} + {1'b0, off};
    // cnt and off are both below Pa, so one conditional subtract is the modulo
    assign pc = CNT_W'((sum >= {1'b0, pa}) ? sum - {1'b0, pa} : sum);
    assign r[i] = pc < da;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) off <= CNT_W'((2 * i) >> LG);
      else if (xfer) off <= CNT_W'(prod >> LG);
  end
  always_comb begin
    hs_n = '0;
    ls_n = '0;
    for (int k = 0; k < NPHASE; k++) begin
      ns[k] = ps[k];
      ndc[k] = dc[k];
      if (halt) begin
        ns[k] = OFF;
        ndc[k] = '0;
      end else if ((ps[k] == DT_TO_HS && r[k]) || (ps[k] == DT_TO_LS && !r[k])) begin
        if (dc[k] == '0) ns[k] = r[k] ? HS : LS;
        else ndc[k] = dc[k] - DT_W'(1);
      end else if (!((ps[k] == HS && r[k]) || (ps[k] == LS && !r[k]))) begin
        // new target (from OFF, a settled state, or a reversal mid-gap): restart the full gap
        ns[k] = (ta == '0) ? (r[k] ? HS : LS) : (r[k] ? DT_TO_HS : DT_TO_LS);
        ndc[k] = ta - DT_W'(1);
      end
      hs_n[k] = ns[k] == HS;
      ls_n[k] = ns[k] == LS;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sp <= CNT_W'(2);
      sd <= '0;
      sdt <= '0;
      pa <= CNT_W'(2);
      da <= '0;
      ta <= '0;
      pend <= 1'b0;
      load_ack <= 1'b0;
      cycle_start <= 1'b0;
      tripped <= 1'b0;
      hs_out <= '0;
      ls_out <= '0;
      for (int k = 0; k < NPHASE; k++) begin
        ps[k] <= OFF;
        dc[k] <= '0;
      end
    end else begin
      cnt <= (!enable || wrap) ? '0 : cnt + CNT_W'(1);
      cycle_start <= enable && wrap;
      if (load) begin
        sp <= period;
        sd <= duty;
        sdt <= deadtime;
      end
      pend <= load || (pend && !xfer);
      load_ack <= xfer;
      if (xfer) begin
        pa <= pn;
        da <= dn;
        ta <= sdt;
      end
      tripped <= enable && (tripped || fault);
      hs_out <= hs_n;
      ls_out <= ls_n;
      for (int k = 0; k < NPHASE; k++) begin
        ps[k] <= ns[k];
        dc[k] <= ndc[k];
      end
    end
  end
endmodule

// File: tb/tb_multiphase_pwm_ctrl.sv
// tb_multiphase_pwm_ctrl: directed scenarios for the 2-phase PWM controller
module tb_multiphase_pwm_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, fault = 1'b0, load = 1'b0;
  logic [15:0] period = '0, duty = '0;
  logic [7:0] deadtime = '0;
  logic load_ack, cycle_start, tripped;
  logic [1:0] hs_out, ls_out;
  int vectors = 0, miscompares = 0;

  multiphase_pwm_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fault(fault), .period(period), .duty(duty),
    .deadtime(deadtime), .load(load), .load_ack(load_ack), .cycle_start(cycle_start),
    .hs_out(hs_out), .ls_out(ls_out), .tripped(tripped)
  );

  always #5 clk = ~clk;

  task automatic program_regs(input int p, input int d, input int t);
    @(negedge clk);
    enable = 1'b0; period = 16'(p); duty = 16'(d); deadtime = 8'(t); load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    vectors++;
    if (load_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL program_ack P=%0d D=%0d: load_ack=%b expected 1", p, d, load_ack);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    #12;
    vectors++;
    if ({hs_out, ls_out, load_ack, cycle_start, tripped} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 0", {hs_out, ls_out, load_ack, cycle_start, tripped});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({hs_out, ls_out, cycle_start, tripped} !== 6'b0) begin
      miscompares++;
      $display("FAIL disabled_idle: got %b expected 0", {hs_out, ls_out, cycle_start, tripped});
    end
  endtask

  task automatic test_interleave;
    program_regs(100, 50, 0);
    enable = 1'b1;
    for (int k = 0; k < 220; k++) begin
      int m;
      logic [4:0] e;
      @(negedge clk);
      m = k % 100;
      e = {m >= 50, m < 50, m < 50, m >= 50, m == 99};
      vectors++;
      if ({hs_out, ls_out, cycle_start} !== e) begin
        miscompares++;
        $display("FAIL interleave k=%0d: hs,ls,cs=%b expected %b", k, {hs_out, ls_out, cycle_start}, e);
      end
    end
  endtask

  task automatic test_deadtime;
    program_regs(100, 30, 5);
    enable = 1'b1;
    for (int k = 0; k < 220; k++) begin
      int m;
      logic [3:0] e;
      @(negedge clk);
      m = k % 100;
      e = {m >= 55 && m < 80, m >= 5 && m < 30, (m >= 85 || m < 50) && k >= 5, m >= 35};
      vectors++;
      if ({hs_out, ls_out} !== e) begin
        miscompares++;
        $display("FAIL deadtime k=%0d: hs,ls=%b expected %b", k, {hs_out, ls_out}, e);
      end
      vectors++;
      if ((hs_out & ls_out) !== 2'b00) begin
        miscompares++;
        $display("FAIL shoot_through k=%0d: hs&ls=%b expected 00", k, hs_out & ls_out);
      end
    end
  endtask

  task automatic test_midload;
    program_regs(100, 30, 0);
    enable = 1'b1;
    for (int k = 0; k < 220; k++) begin
      int m;
      logic [3:0] e;
      @(negedge clk);
      m = k % 100;
      e = {k < 100 ? (m >= 50 && m < 80) : ((m + 50) % 100 < 80), m < (k < 100 ? 30 : 80), k == 99, m == 99};
      vectors++;
      if ({hs_out, load_ack, cycle_start} !== e) begin
        miscompares++;
        $display("FAIL midload k=%0d: hs,ack,cs=%b expected %b", k, {hs_out, load_ack, cycle_start}, e);
      end
      if (k == 39 || k == 59) begin
        duty = (k == 39) ? 16'd90 : 16'd80;
        load = 1'b1;
      end else load = 1'b0;
    end
  endtask

  task automatic test_extremes;
    program_regs(100, 0, 3);
    enable = 1'b1;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      vectors++;
      if ({hs_out, ls_out} !== (k >= 3 ? 4'b0011 : 4'b0000)) begin
        miscompares++;
        $display("FAIL duty_zero k=%0d: hs,ls=%b expected %b", k, {hs_out, ls_out}, k >= 3 ? 4'b0011 : 4'b0000);
      end
    end
    program_regs(100, 150, 3);
    enable = 1'b1;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      vectors++;
      if ({hs_out, ls_out} !== (k >= 3 ? 4'b1100 : 4'b0000)) begin
        miscompares++;
        $display("FAIL duty_full k=%0d: hs,ls=%b expected %b", k, {hs_out, ls_out}, k >= 3 ? 4'b1100 : 4'b0000);
      end
    end
    program_regs(1, 1, 0);
    enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      logic ev;
      @(negedge clk);
      ev = (k % 2) == 0;
      vectors++;
      if ({hs_out, ls_out, cycle_start} !== {!ev, ev, ev, !ev, !ev}) begin
        miscompares++;
        $display("FAIL period_one k=%0d: hs,ls,cs=%b expected %b", k, {hs_out, ls_out, cycle_start}, {!ev, ev, ev, !ev, !ev});
      end
    end
  endtask

  task automatic test_fault;
    program_regs(100, 50, 0);
    enable = 1'b1;
    for (int k = 0; k < 80; k++) begin
      logic [4:0] e;
      @(negedge clk);
      e = (k < 20) ? 5'b01100 : 5'b00001;
      vectors++;
      if ({hs_out, ls_out, tripped} !== e) begin
        miscompares++;
        $display("FAIL fault k=%0d: hs,ls,tripped=%b expected %b", k, {hs_out, ls_out, tripped}, e);
      end
      fault = (k == 19);
    end
    enable = 1'b0;
    @(negedge clk);
    vectors++;
    if ({hs_out, ls_out, tripped} !== 5'b0) begin
      miscompares++;
      $display("FAIL trip_clear: hs,ls,tripped=%b expected 00000", {hs_out, ls_out, tripped});
    end
    enable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      vectors++;
      if ({hs_out, ls_out, tripped} !== 5'b01100) begin
        miscompares++;
        $display("FAIL restart k=%0d: hs,ls,tripped=%b expected 01100", k, {hs_out, ls_out, tripped});
      end
    end
  endtask

  task automatic test_async_reset;
    program_regs(100, 50, 0);
    enable = 1'b1;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({hs_out, ls_out, load_ack, cycle_start, tripped} !== 7'b0) begin
      miscompares++;
      $display("FAIL async_reset: got %b expected 0", {hs_out, ls_out, load_ack, cycle_start, tripped});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      logic [4:0] e;
      @(negedge clk);
      e = {4'b0011, (k % 2) == 1};
      vectors++;
      if ({hs_out, ls_out, cycle_start} !== e) begin
        miscompares++;
        $display("FAIL post_reset k=%0d: hs,ls,cs=%b expected %b", k, {hs_out, ls_out, cycle_start}, e);
      end
    end
  endtask

  initial begin
    test_reset;
    test_interleave;
    test_deadtime;
    test_midload;
    test_extremes;
    test_fault;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
